// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, status bit positions
// and the instruction word held in IR when no instruction is valid.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam int STATUS_Z = 0;
    localparam int STATUS_N = 1;
    localparam int STATUS_C = 2;
    localparam int STATUS_V = 3;

    localparam logic [15:0] NOP_IR_DEFAULT = 16'h0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: address/request out of the fetch unit,
// ready/data back from memory.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready;
    logic [15:0]       mem_data;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ready,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ready,
        output mem_data
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch/execute sequencer: owns the PC, fetches words into IR over a ready
// handshake, holds the status flags and applies redirects when execution finishes.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_IR   = NOP_IR_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    instruction_fetch_unit_if.master mem,
    output logic [15:0]           IR,
    output logic                  ir_valid,
    input  logic                  exec_done,
    input  logic                  branch_taken,
    input  logic [ADDR_W-1:0]     branch_target,
    input  logic                  flag_we,
    input  logic [3:0]            flags_in,
    output logic [3:0]            status,
    input  logic                  halt,
    output logic [ADDR_W-1:0]     pc,
    output logic                  halted
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc_next;
    logic [15:0]       ir_next;
    logic [3:0]        status_next;
    logic              rd_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= PC_INIT;
            IR     <= NOP_IR;
            status <= 4'b0000;
        end else begin
            state  <= next_state;
            pc     <= pc_next;
            IR     <= ir_next;
            status <= status_next;
        end
    end

    // FETCH is also the reset state, so the read request is masked while reset is held.
    always_comb begin
        next_state  = state;
        pc_next     = pc;
        ir_next     = IR;
        status_next = status;
        rd_req      = 1'b0;
        ir_valid    = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH: begin
                rd_req = ~reset;
                if (mem.mem_ready) begin
                    ir_next    = mem.mem_data;
                    pc_next    = pc + ADDR_W'(1);
                    next_state = EXEC;
                end
            end
            EXEC: begin
                ir_valid = 1'b1;
                if (exec_done) begin
                    if (flag_we) begin
                        status_next = flags_in;
                    end
                    if (branch_taken) begin
                        pc_next = branch_target;
                    end
                    next_state = halt ? HALT : FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign mem.mem_rd   = rd_req;
    assign mem.mem_addr = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written reset/halt
// sequences and randomized cycles checked against an instruction-level model.
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       IR;
    logic              ir_valid;
    logic              exec_done;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              flag_we;
    logic [3:0]        flags_in;
    logic [3:0]        status;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) mem_bus ();

    instruction_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(16'h0000),
        .NOP_IR  (16'h0000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mem          (mem_bus),
        .IR           (IR),
        .ir_valid     (ir_valid),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .flag_we      (flag_we),
        .flags_in     (flags_in),
        .status       (status),
        .halt         (halt),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    // Model phases: waiting for an instruction word, running one, stopped for good.
    localparam int WAIT_WORD = 0;
    localparam int RUNNING   = 1;
    localparam int STOPPED   = 2;

    typedef struct {
        logic        ready;
        logic [15:0] data;
        logic        done;
        logic        br;
        logic [15:0] tgt;
        logic        fwe;
        logic [3:0]  flg;
        logic        hlt;
        int          mode;
        logic [15:0] exp_pc;
        logic [15:0] exp_ir;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    int          m_mode;
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [3:0]  m_st;

    function automatic vec_t mk(logic ready, logic [15:0] data, logic done, logic br,
                                logic [15:0] tgt, logic fwe, logic [3:0] flg, logic hlt,
                                int mode, logic [15:0] epc, logic [15:0] eir, logic [3:0] est);
        vec_t v;
        v.ready = ready; v.data = data; v.done = done; v.br = br; v.tgt = tgt;
        v.fwe = fwe; v.flg = flg; v.hlt = hlt; v.mode = mode;
        v.exp_pc = epc; v.exp_ir = eir; v.exp_st = est;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ready, input logic [15:0] data, input logic done,
                                  input logic br, input logic [15:0] tgt, input logic fwe,
                                  input logic [3:0] flg, input logic hlt);
        mem_bus.mem_ready = ready;
        mem_bus.mem_data  = data;
        exec_done         = done;
        branch_taken      = br;
        branch_target     = tgt;
        flag_we           = fwe;
        flags_in          = flg;
        halt              = hlt;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Asserted and released between edges; optionally checks the immediate effect.
    task automatic pulse_reset(input bit check_now, input string tag);
        reset = 1'b1;
        #1;
        if (check_now) begin
            check_output({tag, " rst pc"},       pc,                16'h0000);
            check_output({tag, " rst IR"},       IR,                16'h0000);
            check_output({tag, " rst status"},   {12'h0, status},   16'h0000);
            check_output({tag, " rst mem_rd"},   {15'h0, mem_bus.mem_rd}, 16'h0000);
            check_output({tag, " rst ir_valid"}, {15'h0, ir_valid}, 16'h0000);
            check_output({tag, " rst halted"},   {15'h0, halted},   16'h0000);
        end
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        m_mode = WAIT_WORD;
        m_pc   = 16'h0000;
        m_ir   = 16'h0000;
        m_st   = 4'b0000;
    endtask

    // One clock edge worth of instruction-level behaviour, using the inputs held at the edge.
    task automatic model_edge();
        if (m_mode == WAIT_WORD) begin
            if (mem_bus.mem_ready) begin
                m_ir   = mem_bus.mem_data;
                m_pc   = m_pc + 16'd1;
                m_mode = RUNNING;
            end
        end else if (m_mode == RUNNING) begin
            if (exec_done) begin
                if (flag_we)      m_st = flags_in;
                if (branch_taken) m_pc = branch_target;
                m_mode = halt ? STOPPED : WAIT_WORD;
            end
        end
    endtask

    task automatic compare_model(input int cyc);
        string t;
        t = $sformatf("rnd%0d", cyc);
        check_output({t, " mem_rd"},   {15'h0, mem_bus.mem_rd}, {15'h0, m_mode == WAIT_WORD});
        check_output({t, " mem_addr"}, mem_bus.mem_addr,        m_pc);
        check_output({t, " IR"},       IR,                      m_ir);
        check_output({t, " ir_valid"}, {15'h0, ir_valid},       {15'h0, m_mode == RUNNING});
        check_output({t, " status"},   {12'h0, status},         {12'h0, m_st});
        check_output({t, " halted"},   {15'h0, halted},         {15'h0, m_mode == STOPPED});
    endtask

    initial begin
        int prev_mode;
        logic [15:0] prev_pc;
        int stop_cycles;

        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0);

        // Directed program: fetch, waits, branch with flags, PC wrap, branch+halt.
        vecs.push_back(mk(1, 16'h8123, 0, 0, 16'h0000, 0, 4'h0, 0, RUNNING,   16'h0001, 16'h8123, 4'h0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0, 0, WAIT_WORD, 16'h0001, 16'h8123, 4'h0));
        vecs.push_back(mk(1, 16'h1111, 0, 0, 16'h0000, 0, 4'h0, 0, RUNNING,   16'h0002, 16'h1111, 4'h0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0005, 0, 4'h0, 0, WAIT_WORD, 16'h0005, 16'h1111, 4'h0));
        vecs.push_back(mk(0, 16'hDEAD, 0, 0, 16'h0000, 0, 4'h0, 0, WAIT_WORD, 16'h0005, 16'h1111, 4'h0));
        vecs.push_back(mk(0, 16'hBEEF, 1, 1, 16'h0123, 1, 4'hF, 1, WAIT_WORD, 16'h0005, 16'h1111, 4'h0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 0, WAIT_WORD, 16'h0005, 16'h1111, 4'h0));
        vecs.push_back(mk(1, 16'h2222, 0, 0, 16'h0000, 0, 4'h0, 0, RUNNING,   16'h0006, 16'h2222, 4'h0));
        vecs.push_back(mk(1, 16'h9999, 0, 1, 16'h0099, 1, 4'h7, 1, RUNNING,   16'h0006, 16'h2222, 4'h0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0040, 1, 4'h1, 0, WAIT_WORD, 16'h0040, 16'h2222, 4'h1));
        vecs.push_back(mk(1, 16'h3333, 0, 0, 16'h0000, 0, 4'h0, 0, RUNNING,   16'h0041, 16'h3333, 4'h1));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'hFFFF, 0, 4'hF, 0, WAIT_WORD, 16'hFFFF, 16'h3333, 4'h1));
        vecs.push_back(mk(1, 16'h4444, 0, 0, 16'h0000, 0, 4'h0, 0, RUNNING,   16'h0000, 16'h4444, 4'h1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 1, 4'hA, 0, WAIT_WORD, 16'h0000, 16'h4444, 4'hA));
        vecs.push_back(mk(1, 16'h5555, 0, 0, 16'h0000, 0, 4'h0, 0, RUNNING,   16'h0001, 16'h5555, 4'hA));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h0010, 0, 4'h3, 1, STOPPED,   16'h0010, 16'h5555, 4'hA));

        repeat (2) @(posedge clock);
        #1;
        check_output("reset mem_rd",   {15'h0, mem_bus.mem_rd}, 16'h0000);
        check_output("reset pc",       pc,                      16'h0000);
        check_output("reset IR",       IR,                      16'h0000);
        check_output("reset status",   {12'h0, status},         16'h0000);
        check_output("reset ir_valid", {15'h0, ir_valid},       16'h0000);
        check_output("reset halted",   {15'h0, halted},         16'h0000);
        #2;
        reset = 1'b0;
        #1;

        prev_mode = WAIT_WORD;
        prev_pc   = 16'h0000;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].ready, vecs[i].data, vecs[i].done, vecs[i].br,
                           vecs[i].tgt, vecs[i].fwe, vecs[i].flg, vecs[i].hlt);
            check_output($sformatf("vec%0d pre mem_rd", i), {15'h0, mem_bus.mem_rd},
                         {15'h0, prev_mode == WAIT_WORD});
            check_output($sformatf("vec%0d pre mem_addr", i), mem_bus.mem_addr, prev_pc);
            check_output($sformatf("vec%0d pre ir_valid", i), {15'h0, ir_valid},
                         {15'h0, prev_mode == RUNNING});
            step();
            check_output($sformatf("vec%0d pc", i),     pc,              vecs[i].exp_pc);
            check_output($sformatf("vec%0d IR", i),     IR,              vecs[i].exp_ir);
            check_output($sformatf("vec%0d status", i), {12'h0, status}, {12'h0, vecs[i].exp_st});
            check_output($sformatf("vec%0d halted", i), {15'h0, halted},
                         {15'h0, vecs[i].mode == STOPPED});
            prev_mode = vecs[i].mode;
            prev_pc   = vecs[i].exp_pc;
        end

        // Halted core must ignore memory and datapath activity.
        for (int c = 0; c < 20; c++) begin
            apply_stimulus(c[0], 16'hC0DE, ~c[0], 1'b1, 16'h0ABC, 1'b1, 4'hF, 1'b0);
            step();
            check_output($sformatf("halt%0d mem_rd", c), {15'h0, mem_bus.mem_rd}, 16'h0000);
        end
        check_output("halt halted", {15'h0, halted},   16'h0001);
        check_output("halt pc",     pc,                16'h0010);
        check_output("halt IR",     IR,                16'h5555);
        check_output("halt status", {12'h0, status},   16'h000A);

        // Reset while waiting on memory and while executing.
        pulse_reset(1'b1, "from_halt");
        apply_stimulus(1, 16'hAAAA, 0, 0, 16'h0, 0, 4'h0, 0);
        step();
        apply_stimulus(0, 16'h0000, 1, 1, 16'h0077, 1, 4'h6, 0);
        step();
        apply_stimulus(0, 16'h0000, 0, 0, 16'h0, 0, 4'h0, 0);
        step();
        step();
        check_output("wait mem_rd",   {15'h0, mem_bus.mem_rd}, 16'h0001);
        check_output("wait mem_addr", mem_bus.mem_addr,        16'h0077);
        check_output("wait status",   {12'h0, status},         16'h0006);
        pulse_reset(1'b1, "mid_wait");
        check_output("restart mem_rd",   {15'h0, mem_bus.mem_rd}, 16'h0001);
        check_output("restart mem_addr", mem_bus.mem_addr,        16'h0000);
        apply_stimulus(1, 16'hBBBB, 0, 0, 16'h0, 0, 4'h0, 0);
        step();
        apply_stimulus(0, 16'h0000, 0, 0, 16'h0, 0, 4'h0, 0);
        step();
        check_output("exec ir_valid", {15'h0, ir_valid}, 16'h0001);
        check_output("exec IR",       IR,                16'hBBBB);
        pulse_reset(1'b1, "mid_exec");
        check_output("restart2 mem_addr", mem_bus.mem_addr, 16'h0000);

        // Randomized cycles against the model, re-resetting after each halt.
        pulse_reset(1'b0, "rnd");
        model_reset();
        stop_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus($urandom_range(0, 2) != 0, 16'($urandom),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                           16'($urandom), $urandom_range(0, 1) == 1,
                           4'($urandom), $urandom_range(0, 15) == 0);
            if (c % 97 == 5) begin
                branch_target = 16'hFFFF;
            end
            compare_model(c);
            step();
            model_edge();
            if (m_mode == STOPPED) begin
                stop_cycles++;
                if (stop_cycles > 4) begin
                    pulse_reset(1'b0, "rnd");
                    model_reset();
                    stop_cycles = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
